// File: rtl/bt_uart_tx.sv
// bt_uart_tx: UART 8N1 transmitter fed by a small circular byte FIFO; bit timing from clk / (CLK_HZ/BAUD).
// Latency: a byte pushed into an empty FIFO at edge N is popped at N+1 and the start bit is on tx from N+2.
// Backpressure: tx_ready drops while the FIFO is full; a write attempted then is dropped and sets sticky overflow.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-low
//   tx_data     byte to queue, sampled only when tx_valid && tx_ready
//   tx_valid    write request
//   tx_ready    FIFO not full (combinational from the FIFO count)
//   tx          serial line, idle high, registered
//   busy        high from first start-bit cycle through last stop-bit cycle, registered
//   fifo_count  bytes waiting in the FIFO, not counting the frame on the line
//   overflow    sticky write-while-full flag, cleared only by reset
module bt_uart_tx #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CW           = PTR_W + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]    CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Registered state
  state_t           state_q,   state_d;
  logic [CNT_W-1:0] baud_q,    baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic             tx_q,      tx_d;
  logic             busy_q,    busy_d;
  logic             ovf_q,     ovf_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]    count_q,   count_d;

  logic push;
  logic pop;
  logic fifo_nonempty;
  logic baud_last;

  // Full refuses the write even when a pop happens in the same cycle.
  assign tx_ready      = (count_q != CNT_FULL);
  assign push          = tx_valid && tx_ready;
  assign fifo_nonempty = (count_q != '0);
  assign baud_last     = (baud_q == BAUD_LAST);

  // FSM next state; pop is asserted on the cycle the head byte moves into the shift register.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Back-to-back frames: next start bit follows the stop bit with no idle cycle.
          if (fifo_nonempty) begin
            pop       = 1'b1;
            shift_d   = mem_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line outputs are registered from the current state, so tx trails the state by one cycle;
  // every state lasts CLKS_PER_BIT cycles, so bit widths on tx are unaffected.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE);
    ovf_d  = ovf_q | (tx_valid && !tx_ready);
  end

  // Circular FIFO bookkeeping; pointers wrap naturally since the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_bt_uart_tx.sv
// tb_bt_uart_tx: directed bench for bt_uart_tx at 16 clocks per bit with a 4-deep FIFO.
// A line monitor decodes frames off tx independently of the DUT internals.
// Expected values are hand-derived from the push timing and the byte values driven.
module tb_bt_uart_tx;

  logic       clk      = 1'b0;
  logic       rst      = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  always #5 clk = ~clk;

  bt_uart_tx #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: start detected on a low level, bits sampled mid-cell at 16 clocks per bit.
  logic       mon_en  = 1'b0;
  logic       mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_t0  = 0;
  logic [7:0] mon_sh  = 8'h00;
  logic [7:0] rx_q[$];
  int         st_q[$];
  int         fall_cnt = 0;
  logic       tx_prev  = 1'b1;

  always @(negedge clk) begin
    if (tx_prev && !tx) fall_cnt <= fall_cnt + 1;
    tx_prev <= tx;
    if (!mon_en) begin
      mon_act <= 1'b0;
    end else if (!mon_act) begin
      if (!tx) begin
        mon_act <= 1'b1;
        mon_cnt <= 1;
        mon_t0  <= cyc;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == 8) chk("mon_start_bit", 32'(tx), 32'd0);
      if (mon_cnt >= 24 && mon_cnt <= 136 && (mon_cnt % 16) == 8) mon_sh <= {tx, mon_sh[7:1]};
      if (mon_cnt == 152) begin
        chk("mon_stop_bit", 32'(tx), 32'd1);
        rx_q.push_back(mon_sh);
        st_q.push_back(mon_t0);
      end
      if (mon_cnt == 159) mon_act <= 1'b0;
    end
  end

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < rx_q.size()) return 32'(rx_q[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] st_gap(input int idx);
    if (idx + 1 < st_q.size()) return 32'(st_q[idx+1] - st_q[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int target, input int budget);
    int i = 0;
    while (rx_q.size() < target && i < budget) begin
      step();
      i++;
    end
    chk("wait_rx_frames", 32'(rx_q.size()), 32'(target));
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy || fifo_count != 3'd0) && i < budget) begin
      step();
      i++;
    end
    chk("wait_idle_in_time", 32'(i < budget), 32'd1);
    repeat (20) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         base;
    int         f0;
    int         first_low;
    int         tx_bad;
    int         busy_bad;
    int         busy_cnt;
    int         b;
    logic       exp_tx;
    logic       exp_busy;
    logic [7:0] t2_byte;

    // Test 1: reset values and a quiet idle line
    rst = 1'b0;
    repeat (3) step();
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      step();
      if (tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1 || fifo_count !== 3'd0 || overflow !== 1'b0)
        bad++;
    end
    chk("t1_idle_bad_cycles", 32'(bad), 32'd0);
    mon_en = 1'b1;

    // Test 2: single 0xA5 frame, exact cycle timing of tx and busy
    t2_byte   = 8'hA5;
    base      = rx_q.size();
    tx_data   = 8'hA5;
    tx_valid  = 1'b1;
    step();
    tx_valid  = 1'b0;
    tx_data   = 8'hFF;
    first_low = -1;
    tx_bad    = 0;
    busy_bad  = 0;
    busy_cnt  = 0;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (k >= 2 && k <= 161) begin
        b        = (k - 2) / 16;
        exp_busy = 1'b1;
        if (b == 0)      exp_tx = 1'b0;
        else if (b == 9) exp_tx = 1'b1;
        else             exp_tx = t2_byte[b-1];
      end else begin
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
      end
      if (tx !== exp_tx) tx_bad++;
      if (busy !== exp_busy) busy_bad++;
      if (busy === 1'b1) busy_cnt++;
      if (tx === 1'b0 && first_low < 0) first_low = k;
    end
    chk("t2_first_low_cycle", 32'(first_low), 32'd2);
    chk("t2_tx_bad_cycles", 32'(tx_bad), 32'd0);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd160);
    chk("t2_busy_bad_cycles", 32'(busy_bad), 32'd0);
    chk("t2_frames", 32'(rx_q.size() - base), 32'd1);
    chk("t2_byte", rx_at(base), 32'hA5);

    // Test 3: three back-to-back frames, count 2,1,0 across pops
    base     = rx_q.size();
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    step();
    tx_data  = 8'h02;
    step();
    tx_data  = 8'h03;
    step();
    tx_valid = 1'b0;
    chk("t3_count_after_push", 32'(fifo_count), 32'd2);
    repeat (158) step();
    chk("t3_count_before_pop2", 32'(fifo_count), 32'd2);
    step();
    chk("t3_count_after_pop2", 32'(fifo_count), 32'd1);
    repeat (160) step();
    chk("t3_count_after_pop3", 32'(fifo_count), 32'd0);
    wait_rx(base + 3, 400);
    chk("t3_byte0", rx_at(base), 32'h01);
    chk("t3_byte1", rx_at(base + 1), 32'h02);
    chk("t3_byte2", rx_at(base + 2), 32'h03);
    chk("t3_gap01", st_gap(base), 32'd160);
    chk("t3_gap12", st_gap(base + 1), 32'd160);
    wait_idle(600);

    // Test 4: six writes into idle TX; sixth refused, overflow sticky, five frames
    base     = rx_q.size();
    tx_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = 8'h10 + 8'(i);
      step();
      if (i == 4) begin
        chk("t4_ready_full", 32'(tx_ready), 32'd0);
        chk("t4_count_full", 32'(fifo_count), 32'd4);
        chk("t4_ovf_before", 32'(overflow), 32'd0);
      end
    end
    tx_valid = 1'b0;
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    chk("t4_count_refused", 32'(fifo_count), 32'd4);
    wait_rx(base + 5, 1000);
    repeat (200) step();
    chk("t4_frames", 32'(rx_q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++) chk("t4_byte", rx_at(base + i), 32'h10 + 32'(i));
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    wait_idle(200);

    // Test 6: push on the same edge as a pop with count 2
    base     = rx_q.size();
    tx_valid = 1'b1;
    tx_data  = 8'h21;
    step();
    tx_data  = 8'h22;
    step();
    tx_data  = 8'h23;
    step();
    tx_valid = 1'b0;
    repeat (158) step();
    chk("t6_count_before", 32'(fifo_count), 32'd2);
    tx_valid = 1'b1;
    tx_data  = 8'h24;
    step();
    tx_valid = 1'b0;
    chk("t6_count_after", 32'(fifo_count), 32'd2);
    wait_rx(base + 4, 800);
    for (int i = 0; i < 4; i++) chk("t6_byte", rx_at(base + i), 32'h21 + 32'(i));
    wait_idle(400);

    // Test 5: reset during DATA bit 3 of 0x00 truncates the frame and flushes the FIFO
    mon_en   = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    step();
    tx_data  = 8'h55;
    step();
    tx_valid = 1'b0;
    repeat (69) step();
    chk("t5_tx_pre", 32'(tx), 32'd0);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    chk("t5_count_pre", 32'(fifo_count), 32'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_tx_rst", 32'(tx), 32'd1);
    chk("t5_busy_rst", 32'(busy), 32'd0);
    chk("t5_count_rst", 32'(fifo_count), 32'd0);
    chk("t5_ovf_rst", 32'(overflow), 32'd0);
    chk("t5_ready_rst", 32'(tx_ready), 32'd1);
    f0 = fall_cnt;
    repeat (300) step();
    chk("t5_no_tx_edges", 32'(fall_cnt - f0), 32'd0);
    chk("t5_tx_idle", 32'(tx), 32'd1);
    chk("t5_busy_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
